// File: rtl/mack_bus_pkg.sv
// Shared definitions for the Mackerel 68000-style bus initiator.
// Contents:
//   state_t          - bus-cycle FSM states
//   BE_UPPER/LOWER/WORD - byte-enable encodings ([1] = UDS, [0] = LDS)
//   TIMEOUT_DEFAULT  - default number of WAIT cycles before a forced bus error
//   norm_be()        - maps the "no lanes" encoding onto a full word access
package mack_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_STROBE  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_END     = 3'd4,
        ST_RECOVER = 3'd5
    } state_t;

    localparam logic [1:0] BE_UPPER = 2'b10;
    localparam logic [1:0] BE_LOWER = 2'b01;
    localparam logic [1:0] BE_WORD  = 2'b11;

    localparam int TIMEOUT_DEFAULT = 64;

    // A request with no byte lanes selected is run as a full word access.
    function automatic logic [1:0] norm_be(input logic [1:0] be);
        logic [1:0] res;
        if (be == 2'b00) begin
            res = BE_WORD;
        end else begin
            res = be;
        end
        return res;
    endfunction

endpackage

// File: rtl/mack_sync2.sv
// Two-flop synchronizer for asynchronous active-low bus handshake inputs.
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset; both stages reset to all-ones
//          (the negated level of the active-low inputs)
//   d    - asynchronous input vector
//   q    - synchronized output vector
module mack_sync2 #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    import mack_bus_pkg::*;

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the asynchronous inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= '1;
            sync_r <= '1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/mack_bus_master.sv
// Single-transfer 68000-style asynchronous bus initiator.
// Runs one bus cycle per accepted request: address setup, AS_N, data
// strobes, wait for DTACK_N/BERR_N (or time out), strobe release with a
// one-cycle ACK, then a recovery phase until the responder negates its
// handshake lines.
// Ports:
//   CLK, RST                 - clock, synchronous active-high reset
//   REQ, REQ_ADDR, REQ_WR,
//   REQ_BE, REQ_WDATA        - request from the internal agent (sampled in IDLE)
//   ACK, RSP_RDATA, RSP_BERR - completion pulse, read data, error flag
//   BUSY                     - high while a bus cycle is in progress
//   A, D_OUT, D_OE, D_IN     - address and data bus
//   AS_N, UDS_N, LDS_N, RW   - bus strobes and direction
//   DTACK_N, BERR_N          - asynchronous responder handshake inputs
// All outputs are registered.
module mack_bus_master
    import mack_bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic [22:0] REQ_ADDR,
    input  logic        REQ_WR,
    input  logic [1:0]  REQ_BE,
    input  logic [15:0] REQ_WDATA,
    output logic        ACK,
    output logic [15:0] RSP_RDATA,
    output logic        RSP_BERR,
    output logic        BUSY,
    output logic [22:0] A,
    output logic [15:0] D_OUT,
    output logic        D_OE,
    input  logic [15:0] D_IN,
    output logic        AS_N,
    output logic        UDS_N,
    output logic        LDS_N,
    output logic        RW,
    input  logic        DTACK_N,
    input  logic        BERR_N
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          wr_r, wr_s;
    logic [1:0]    be_r, be_s;

    logic          ack_s, rsp_berr_s, busy_s, d_oe_s;
    logic          as_n_s, uds_n_s, lds_n_s, rw_s;
    logic [15:0]   rsp_rdata_s, d_out_s;
    logic [22:0]   a_s;

    logic [1:0]    hs_sync_s;
    logic          dtack_n_sync_s;
    logic          berr_n_sync_s;

    mack_sync2 #(.WIDTH(2)) u_sync (
        .clk (CLK),
        .rst (RST),
        .d   ({DTACK_N, BERR_N}),
        .q   (hs_sync_s)
    );

    assign dtack_n_sync_s = hs_sync_s[1];
    assign berr_n_sync_s  = hs_sync_s[0];

    // Next-state and next-output computation; outputs are registered from these.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        wr_s        = wr_r;
        be_s        = be_r;
        ack_s       = 1'b0;
        rsp_berr_s  = RSP_BERR;
        rsp_rdata_s = RSP_RDATA;
        a_s         = A;
        d_out_s     = D_OUT;
        d_oe_s      = D_OE;
        as_n_s      = AS_N;
        uds_n_s     = UDS_N;
        lds_n_s     = LDS_N;
        rw_s        = RW;

        case (state_r)
            ST_IDLE: begin
                if (REQ) begin
                    state_s = ST_ADDR;
                    wr_s    = REQ_WR;
                    be_s    = norm_be(REQ_BE);
                    a_s     = REQ_ADDR;
                    rw_s    = ~REQ_WR;
                    if (REQ_WR) begin
                        d_out_s = REQ_WDATA;
                        d_oe_s  = 1'b1;
                    end else begin
                        d_out_s = 16'h0000;
                        d_oe_s  = 1'b0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_ADDR: begin
                state_s = ST_STROBE;
                as_n_s  = 1'b0;
                // Reads drive the data strobes together with AS_N.
                if (!wr_r) begin
                    uds_n_s = ~be_r[1];
                    lds_n_s = ~be_r[0];
                end else begin
                    uds_n_s = 1'b1;
                    lds_n_s = 1'b1;
                end
            end

            ST_STROBE: begin
                state_s = ST_WAIT;
                cnt_s   = {CW{1'b0}};
                // Writes drive the data strobes one cycle after AS_N so the
                // data bus is settled before the responder latches it.
                if (wr_r) begin
                    uds_n_s = ~be_r[1];
                    lds_n_s = ~be_r[0];
                end else begin
                    uds_n_s = UDS_N;
                    lds_n_s = LDS_N;
                end
            end

            ST_WAIT: begin
                // BERR has priority over DTACK; read data is only taken on a
                // clean acknowledge.
                if (!berr_n_sync_s) begin
                    state_s    = ST_END;
                    ack_s      = 1'b1;
                    rsp_berr_s = 1'b1;
                end else if (!dtack_n_sync_s) begin
                    state_s    = ST_END;
                    ack_s      = 1'b1;
                    rsp_berr_s = 1'b0;
                    if (!wr_r) begin
                        rsp_rdata_s = D_IN;
                    end else begin
                        rsp_rdata_s = RSP_RDATA;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    state_s    = ST_END;
                    ack_s      = 1'b1;
                    rsp_berr_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end

                if (state_s == ST_END) begin
                    as_n_s  = 1'b1;
                    uds_n_s = 1'b1;
                    lds_n_s = 1'b1;
                end else begin
                    as_n_s  = AS_N;
                end
            end

            ST_END: begin
                // D_OE was held through END for write data hold time.
                state_s    = ST_RECOVER;
                cnt_s      = {CW{1'b0}};
                d_oe_s     = 1'b0;
                rw_s       = 1'b1;
                rsp_berr_s = 1'b0;
            end

            ST_RECOVER: begin
                // Leave once the responder has released its handshake, or give
                // up after TIMEOUT cycles so a stuck line cannot hang the bus.
                if ((dtack_n_sync_s && berr_n_sync_s) || (cnt_r == CNT_LAST)) begin
                    state_s = ST_IDLE;
                    a_s     = 23'h000000;
                    d_out_s = 16'h0000;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end

            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CW{1'b0}};
                as_n_s  = 1'b1;
                uds_n_s = 1'b1;
                lds_n_s = 1'b1;
                rw_s    = 1'b1;
                d_oe_s  = 1'b0;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State, bookkeeping and registered bus/response outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            wr_r      <= 1'b0;
            be_r      <= 2'b00;
            ACK       <= 1'b0;
            RSP_BERR  <= 1'b0;
            RSP_RDATA <= 16'h0000;
            BUSY      <= 1'b0;
            A         <= 23'h000000;
            D_OUT     <= 16'h0000;
            D_OE      <= 1'b0;
            AS_N      <= 1'b1;
            UDS_N     <= 1'b1;
            LDS_N     <= 1'b1;
            RW        <= 1'b1;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            wr_r      <= wr_s;
            be_r      <= be_s;
            ACK       <= ack_s;
            RSP_BERR  <= rsp_berr_s;
            RSP_RDATA <= rsp_rdata_s;
            BUSY      <= busy_s;
            A         <= a_s;
            D_OUT     <= d_out_s;
            D_OE      <= d_oe_s;
            AS_N      <= as_n_s;
            UDS_N     <= uds_n_s;
            LDS_N     <= lds_n_s;
            RW        <= rw_s;
        end
    end

endmodule
